// File: rtl/idelay_tap_ctrl.sv
// idelay_tap_ctrl: multi-channel tap controller for IDELAYE2 elements in VAR_LOAD mode.
//
// Accepts SET/INC/DEC/SWEEP commands over a valid/ready handshake, drives the
// per-channel CNTVALUEIN registers with a coincident one-cycle LD strobe, then
// checks the CNTVALUEOUT readback against the intended tap.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   cal_rdy           calibrator ready; low zeroes all taps and blocks commands
//   cmd_valid/ready   command handshake
//   cmd_op            0=SET, 1=INC, 2=DEC, 3=SWEEP
//   cmd_ch            target channel
//   cmd_value         SET: new tap; SWEEP: bit0 1=start, 0=stop
//   dly_ld            per-channel LD pulse
//   dly_cntvaluein    per-channel tap, channel i at [i*TAP_W +: TAP_W]
//   dly_cntvalueout   per-channel readback, same packing
//   tap_out           registered readback of the last addressed channel
//   busy              load sequence in progress
//   sweep_active      sweep running
//   sweep_wrap        pulse in the LOAD cycle of a sweep step landing on tap 0
//   err               sticky readback mismatch / out-of-range channel flag
module idelay_tap_ctrl #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned TAP_W        = 5,
  parameter int unsigned CH_W         = 2,
  parameter int unsigned DWELL_CYCLES = 1000000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cal_rdy,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [CH_W-1:0]           cmd_ch,
  input  logic [TAP_W-1:0]          cmd_value,
  output logic [CHANNELS-1:0]       dly_ld,
  output logic [CHANNELS*TAP_W-1:0] dly_cntvaluein,
  input  logic [CHANNELS*TAP_W-1:0] dly_cntvalueout,
  output logic [TAP_W-1:0]          tap_out,
  output logic                      busy,
  output logic                      sweep_active,
  output logic                      sweep_wrap,
  output logic                      err
);

  localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
  localparam logic [DwellW-1:0] DwellReload = DwellW'(DWELL_CYCLES - 1);

  localparam logic [1:0] OpSet   = 2'd0;
  localparam logic [1:0] OpInc   = 2'd1;
  localparam logic [1:0] OpDec   = 2'd2;
  localparam logic [1:0] OpSweep = 2'd3;

  typedef enum logic [2:0] {StIdle, StLoad, StSettle, StVerify, StDwell} state_e;

  state_e            state_q, state_d;
  logic [TAP_W-1:0]  tap_q [CHANNELS];
  logic [TAP_W-1:0]  tap_d [CHANNELS];
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
  logic [CH_W-1:0]   sweep_ch_q, sweep_ch_d;
  logic              sweep_q, sweep_d;
  logic              step_q, step_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic              err_q, err_d;
  logic [TAP_W-1:0]  tap_out_q;

  logic              accept;
  logic              in_range;
  logic [TAP_W-1:0]  cur_tap;
  logic [TAP_W-1:0]  rb_tap;

  assign cmd_ready = cal_rdy && !RST && (state_q == StIdle || state_q == StDwell);
  assign accept    = cmd_valid && cmd_ready;
  assign in_range  = 32'(cmd_ch) < CHANNELS;
  assign rb_tap    = dly_cntvalueout[ch_q*TAP_W +: TAP_W];

  always_comb begin
    cur_tap = '0;
    if (in_range) cur_tap = tap_q[cmd_ch];
  end

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    ch_d       = ch_q;
    rd_ch_d    = rd_ch_q;
    sweep_ch_d = sweep_ch_q;
    sweep_d    = sweep_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle, StDwell: begin
        if (accept) begin
          // Any accepted command ends a running sweep.
          sweep_d = 1'b0;
          step_d  = 1'b0;
          if (!in_range) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            rd_ch_d = cmd_ch;
            unique case (cmd_op)
              OpSet: begin
                tap_d[cmd_ch] = cmd_value;
                ch_d          = cmd_ch;
                state_d       = StLoad;
              end
              OpInc: begin
                tap_d[cmd_ch] = cur_tap + 1'b1;
                ch_d          = cmd_ch;
                state_d       = StLoad;
              end
              OpDec: begin
                tap_d[cmd_ch] = cur_tap - 1'b1;
                ch_d          = cmd_ch;
                state_d       = StLoad;
              end
              OpSweep: begin
                if (cmd_value[0]) begin
                  sweep_d    = 1'b1;
                  sweep_ch_d = cmd_ch;
                  dwell_d    = DwellReload;
                  state_d    = StDwell;
                end else begin
                  state_d = StIdle;
                end
              end
            endcase
          end
        end else if (state_q == StDwell) begin
          if (dwell_q == '0) begin
            tap_d[sweep_ch_q] = tap_q[sweep_ch_q] + 1'b1;
            ch_d              = sweep_ch_q;
            step_d            = 1'b1;
            state_d           = StLoad;
          end else begin
            dwell_d = dwell_q - 1'b1;
          end
        end
      end
      StLoad:   state_d = StSettle;
      StSettle: state_d = StVerify;
      StVerify: begin
        if (rb_tap != tap_q[ch_q]) err_d = 1'b1;
        step_d  = 1'b0;
        dwell_d = DwellReload;
        state_d = sweep_q ? StDwell : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Losing calibration overrides everything except the sticky error.
    if (!cal_rdy) begin
      state_d = StIdle;
      sweep_d = 1'b0;
      step_d  = 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) tap_d[i] = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      tap_q      <= '{default: '0};
      ch_q       <= '0;
      rd_ch_q    <= '0;
      sweep_ch_q <= '0;
      sweep_q    <= 1'b0;
      step_q     <= 1'b0;
      dwell_q    <= '0;
      err_q      <= 1'b0;
      tap_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      ch_q       <= ch_d;
      rd_ch_q    <= rd_ch_d;
      sweep_ch_q <= sweep_ch_d;
      sweep_q    <= sweep_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      err_q      <= err_d;
      tap_out_q  <= dly_cntvalueout[rd_ch_q*TAP_W +: TAP_W];
    end
  end

  // LD follows the registered state, so a reset or calibration drop squashes it.
  always_comb begin
    dly_ld = '0;
    if (state_q == StLoad) dly_ld[ch_q] = 1'b1;
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_taps
    assign dly_cntvaluein[i*TAP_W +: TAP_W] = tap_q[i];
  end

  assign tap_out      = tap_out_q;
  assign busy         = (state_q == StLoad) || (state_q == StSettle) || (state_q == StVerify);
  assign sweep_active = sweep_q;
  assign sweep_wrap   = (state_q == StLoad) && step_q && (tap_q[ch_q] == '0);
  assign err          = err_q;

endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// Self-checking bench for idelay_tap_ctrl: a 4-channel instance with an echoing
// IDELAY model and a scoreboard of expected LD events, plus a 3-channel
// instance for the out-of-range channel case.
module tb_idelay_tap_ctrl;

  localparam int Dwell = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cal_rdy;
  logic        cmd_valid, cmd_valid1;
  logic        cmd_ready, cmd_ready1;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_ch;
  logic [4:0]  cmd_value;
  logic [3:0]  dly_ld;
  logic [19:0] cvi, cvo;
  logic [4:0]  tap_out, tap_out1;
  logic        busy, sweep_active, sweep_wrap, err;
  logic [2:0]  dly_ld1;
  logic [14:0] cvi1;
  logic        busy1, sweep_active1, sweep_wrap1, err1;
  logic        force_bad;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  ld;
    logic [19:0] cvi;
    int          cyc;
    logic        wrap;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [4:0] exp_tap [4];
  logic       exp_err;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  idelay_tap_ctrl #(
    .CHANNELS(4), .TAP_W(5), .CH_W(2), .DWELL_CYCLES(Dwell)
  ) u_dut (
    .CLK(CLK), .RST(RST), .cal_rdy(cal_rdy), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_value(cmd_value), .dly_ld(dly_ld),
    .dly_cntvaluein(cvi), .dly_cntvalueout(cvo), .tap_out(tap_out), .busy(busy),
    .sweep_active(sweep_active), .sweep_wrap(sweep_wrap), .err(err)
  );

  idelay_tap_ctrl #(
    .CHANNELS(3), .TAP_W(5), .CH_W(2), .DWELL_CYCLES(Dwell)
  ) u_dut3 (
    .CLK(CLK), .RST(RST), .cal_rdy(cal_rdy), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_value(cmd_value), .dly_ld(dly_ld1),
    .dly_cntvaluein(cvi1), .dly_cntvalueout(cvi1), .tap_out(tap_out1), .busy(busy1),
    .sweep_active(sweep_active1), .sweep_wrap(sweep_wrap1), .err(err1)
  );

  // IDELAY model: CNTVALUEOUT follows CNTVALUEIN one cycle after LD.
  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++)
      if (dly_ld[i]) cvo[i*5 +: 5] <= force_bad ? 5'd3 : cvi[i*5 +: 5];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic push_ld(input int c, input int at, input logic wrap);
    exp_t e;
    e.ld   = 4'b0001 << c;
    e.cvi  = {exp_tap[3], exp_tap[2], exp_tap[1], exp_tap[0]};
    e.cyc  = at;
    e.wrap = wrap;
    exp_q.push_back(e);
  endtask

  // Drive one command, wait (bounded) for acceptance, record expectation.
  task automatic issue(input logic [1:0] o, input logic [1:0] c, input logic [4:0] v,
                       output int acc);
    logic [4:0] tgt;
    int n;
    @(negedge CLK);
    cmd_op = o; cmd_ch = c; cmd_value = v; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    acc = cyc;
    if (!cmd_ready) begin
      check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (o != 2'd3) begin
      tgt = v;
      if (o == 2'd1) tgt = exp_tap[c] + 5'd1;
      if (o == 2'd2) tgt = exp_tap[c] - 5'd1;
      exp_tap[c] = tgt;
      push_ld(int'(c), acc + 1, 1'b0);
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic post(input int acc, input logic [4:0] tout);
    wait_cyc(acc + 1);
    check_eq("busy_t1", 32'(busy), 32'd1);
    wait_cyc(acc + 4);
    check_eq("ready_t4", 32'(cmd_ready), 32'd1);
    check_eq("err_t4", 32'(err), 32'(exp_err));
    check_eq("tap_out_t4", 32'(tap_out), 32'(tout));
  endtask

  task automatic check_reset_outs();
    check_eq("rst_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_ld", 32'(dly_ld), 32'd0);
    check_eq("rst_cvi", 32'(cvi), 32'd0);
    check_eq("rst_tap_out", 32'(tap_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sweep", 32'(sweep_active), 32'd0);
    check_eq("rst_wrap", 32'(sweep_wrap), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
  endtask

  // Scoreboard monitor: every LD pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (dly_ld != 4'd0) begin
      if (exp_q.size() == 0) begin
        check_eq("ld_unexpected", 32'(dly_ld), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("ld_mask", 32'(dly_ld), 32'(mon_e.ld));
        check_eq("ld_cvi", 32'(cvi), 32'(mon_e.cvi));
        check_eq("ld_cycle", 32'(cyc), 32'(mon_e.cyc));
        check_eq("ld_wrap", 32'(sweep_wrap), 32'(mon_e.wrap));
      end
    end else if (sweep_wrap) begin
      check_eq("wrap_stray", 32'(sweep_wrap), 32'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    RST = 1'b1; cal_rdy = 1'b1; cmd_valid = 1'b0; cmd_valid1 = 1'b0;
    cmd_op = '0; cmd_ch = '0; cmd_value = '0; force_bad = 1'b0; cvo = '0;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) exp_tap[i] = '0;

    repeat (3) @(negedge CLK);
    check_reset_outs();
    RST = 1'b0;
    @(negedge CLK);
    check_eq("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Out-of-range channel on the 3-channel instance.
    check_eq("oor_err_before", 32'(err1), 32'd0);
    cmd_op = 2'd0; cmd_ch = 2'd3; cmd_value = 5'd7; cmd_valid1 = 1'b1;
    @(negedge CLK);
    cmd_valid1 = 1'b0;
    check_eq("oor_ld", 32'(dly_ld1), 32'd0);
    check_eq("oor_err", 32'(err1), 32'd1);
    check_eq("oor_ready", 32'(cmd_ready1), 32'd1);
    check_eq("oor_busy", 32'(busy1), 32'd0);
    @(negedge CLK);
    check_eq("oor_ld2", 32'(dly_ld1), 32'd0);
    check_eq("oor_cvi", 32'(cvi1), 32'd0);

    // Basic SET and wrap-around INC/DEC.
    issue(2'd0, 2'd2, 5'd17, acc); post(acc, 5'd17);
    issue(2'd0, 2'd0, 5'd31, acc); post(acc, 5'd31);
    issue(2'd1, 2'd0, 5'd0, acc);  post(acc, 5'd0);
    issue(2'd2, 2'd0, 5'd0, acc);  post(acc, 5'd31);

    // Sweep on ch1 from tap 30: 31, 0 (wrap), 1 at 11-cycle steps.
    issue(2'd0, 2'd1, 5'd30, acc); post(acc, 5'd30);
    issue(2'd3, 2'd1, 5'd1, acc);
    for (int k = 0; k < 3; k++) begin
      exp_tap[1] = exp_tap[1] + 5'd1;
      push_ld(1, acc + Dwell + 1 + k * (Dwell + 3), exp_tap[1] == 5'd0);
    end
    check_eq("sweep_on", 32'(sweep_active), 32'd1);
    check_eq("sweep_not_busy", 32'(busy), 32'd0);
    wait_cyc(acc + 36);
    issue(2'd0, 2'd3, 5'd5, acc2);
    check_eq("sweep_off", 32'(sweep_active), 32'd0);
    post(acc2, 5'd5);
    wait_cyc(acc2 + 20);
    check_eq("slice1_frozen", 32'(cvi[9:5]), 32'd1);
    check_eq("slice3", 32'(cvi[19:15]), 32'd5);

    // Readback mismatch; err must stay set across good commands.
    force_bad = 1'b1;
    issue(2'd0, 2'd1, 5'd9, acc);
    exp_err = 1'b1;
    post(acc, 5'd3);
    force_bad = 1'b0;
    issue(2'd0, 2'd2, 5'd4, acc); post(acc, 5'd4);

    // Calibration drop during SETTLE.
    issue(2'd0, 2'd0, 5'd12, acc);
    wait_cyc(acc + 2);
    cal_rdy = 1'b0;
    wait_cyc(acc + 3);
    for (int i = 0; i < 4; i++) exp_tap[i] = '0;
    check_eq("cal_cvi", 32'(cvi), 32'd0);
    check_eq("cal_busy", 32'(busy), 32'd0);
    check_eq("cal_ready", 32'(cmd_ready), 32'd0);
    check_eq("cal_err_kept", 32'(err), 32'd1);
    repeat (3) @(negedge CLK);
    check_eq("cal_ready_low", 32'(cmd_ready), 32'd0);
    cal_rdy = 1'b1;
    @(negedge CLK);
    check_eq("cal_ready_back", 32'(cmd_ready), 32'd1);

    // Reset during LOAD.
    issue(2'd0, 2'd0, 5'd20, acc);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outs();
    RST = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) exp_tap[i] = '0;
    issue(2'd1, 2'd0, 5'd0, acc); post(acc, 5'd1);

    repeat (4) @(negedge CLK);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
